// File: rtl/fetch_pkg.sv
// Shared pipeline definitions: NOP/HALT encodings, the IF/ID record with its
// bubble value, and the fetch state encoding.
package pipe_defs;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  OP_HALT   = 5'b00000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_inc: 16'h0000, valid: 1'b0};

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction cache (slave).
interface fetch_if;

  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        imem_err;

  modport master (
    output imem_addr,
    output imem_rd,
    input  imem_data,
    input  imem_done,
    input  imem_err
  );

  modport slave (
    input  imem_addr,
    input  imem_rd,
    output imem_data,
    output imem_done,
    output imem_err
  );

endinterface

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder; the final carry is not exported since the PC
// incrementer wraps modulo 2^16.
module rca_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum
);

  logic [15:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
    if (i < 15) begin : g_carry
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage with one-entry skid buffer and the IF/ID register.
//
//   state | meaning
//   FETCH | request outstanding at pc; imem_rd=1, address held until done
//   HOLD  | response captured in skid while decode stalls; no request
//   HALT  | HALT instruction fetched; idle until a redirect
module fetch
  import pipe_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_hazard,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  fetch_if.master     imem,
  output logic [15:0] instruct,
  output logic [15:0] pc_inc,
  output logic        valid,
  output logic        err
);

  fetch_state_t state, state_n;
  logic [15:0]  pc, pc_n;
  logic [15:0]  tgt, tgt_n;
  logic         squash, squash_n;
  logic [15:0]  skid_instr, skid_instr_n;
  logic [15:0]  skid_pcinc, skid_pcinc_n;
  ifid_t        ifid, ifid_n;
  logic         err_n;
  logic         rd;
  logic [15:0]  pc_plus2;

  rca_16b u_pc_inc (
    .a    (pc),
    .b    (16'd2),
    .c_in (1'b0),
    .sum  (pc_plus2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= 16'h0000;
      tgt        <= 16'h0000;
      squash     <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pcinc <= 16'h0000;
      ifid       <= BUBBLE;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      tgt        <= tgt_n;
      squash     <= squash_n;
      skid_instr <= skid_instr_n;
      skid_pcinc <= skid_pcinc_n;
      ifid       <= ifid_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    tgt_n        = tgt;
    squash_n     = squash;
    skid_instr_n = skid_instr;
    skid_pcinc_n = skid_pcinc;
    ifid_n       = ifid;
    rd           = 1'b0;

    case (state)
      FETCH: begin
        rd = 1'b1;
        if (imem.imem_done && (redirect || squash)) begin
          // wrong-path data: drop it and restart at the newest target
          pc_n     = redirect ? redirect_pc : tgt;
          squash_n = 1'b0;
          if (redirect || !stall_hazard) ifid_n = BUBBLE;
        end else if (imem.imem_done && !stall_hazard) begin
          ifid_n = '{instr: imem.imem_data, pc_inc: pc_plus2, valid: 1'b1};
          pc_n   = pc_plus2;
          if (is_halt(imem.imem_data)) state_n = HALT;
        end else if (imem.imem_done) begin
          skid_instr_n = imem.imem_data;
          skid_pcinc_n = pc_plus2;
          pc_n         = pc_plus2;
          state_n      = HOLD;
        end else if (redirect) begin
          // the in-flight access cannot be aborted, so remember the target
          squash_n = 1'b1;
          tgt_n    = redirect_pc;
          ifid_n   = BUBBLE;
        end else if (!stall_hazard) begin
          ifid_n = BUBBLE;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          ifid_n  = BUBBLE;
          state_n = FETCH;
        end else if (!stall_hazard) begin
          ifid_n  = '{instr: skid_instr, pc_inc: skid_pcinc, valid: 1'b1};
          state_n = is_halt(skid_instr) ? HALT : FETCH;
        end
      end

      HALT: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          ifid_n  = BUBBLE;
          state_n = FETCH;
        end else if (!stall_hazard) begin
          ifid_n = BUBBLE;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

  assign err_n = err | (rd & (pc[0] | imem.imem_err));

  assign imem.imem_addr = pc;
  assign imem.imem_rd   = rd;
  assign instruct       = ifid.instr;
  assign pc_inc         = ifid.pc_inc;
  assign valid          = ifid.valid;

endmodule
